// File: rtl/ecc_io_pkg.sv
// Shared ECC I/O constants and types, used by the word loader and the result serializer.
package ecc_io_pkg;

   localparam int unsigned ECC_W  = 164;
   localparam int unsigned WORD_W = 64;
   localparam int unsigned WPC    = 3;
   localparam int unsigned IDX_W  = $clog2(2*WPC + 1);

   typedef enum logic [1:0] {IDLE, SEND, DONE} ser_state_t;

   typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/ecc_result_serializer.sv
// Captures the ECC result point (Pox, Poy) on edone and streams it out as WORD_W words.
// Optional macro ECC_SER_CHECKSUM_EN appends an XOR checksum word after the last coordinate word.
module ecc_result_serializer
   import ecc_io_pkg::*;
(
   input  logic              clk,
   input  logic              n_rst,
   input  logic              edone,
   input  logic [ECC_W-1:0]  Pox,
   input  logic [ECC_W-1:0]  Poy,
   input  logic              read_ack,
   output logic [WORD_W-1:0] data_out,
   output logic              data_ready,
   output logic              busy,
   output logic              done,
   output logic              overrun
);

   localparam int unsigned PAD_W = WPC * WORD_W;
`ifdef ECC_SER_CHECKSUM_EN
   localparam int unsigned N_WORDS = 2*WPC + 1;
`else
   localparam int unsigned N_WORDS = 2*WPC;
`endif
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

   if (WPC != (ECC_W + WORD_W - 1) / WORD_W) begin : g_wpc_check
      $error("WPC must equal ceil(ECC_W/WORD_W)");
   end

   ser_state_t        state;
   logic [IDX_W-1:0]  idx;
   logic [ECC_W-1:0]  cap_x;
   logic [ECC_W-1:0]  cap_y;
   logic [PAD_W-1:0]  x_pad;
   logic [PAD_W-1:0]  y_pad;
   word_t             sel_word;
`ifdef ECC_SER_CHECKSUM_EN
   word_t             csum;
`endif

   // Zero-extend each coordinate to a whole number of words; the pad lands in the top word.
   assign x_pad = PAD_W'(cap_x);
   assign y_pad = PAD_W'(cap_y);

   always_comb begin
      sel_word = '0;
`ifdef ECC_SER_CHECKSUM_EN
      csum = '0;
`endif
      for (int unsigned i = 0; i < WPC; i++) begin
         if (idx == IDX_W'(i))
            sel_word = x_pad[i*WORD_W +: WORD_W];
         if (idx == IDX_W'(WPC + i))
            sel_word = y_pad[i*WORD_W +: WORD_W];
`ifdef ECC_SER_CHECKSUM_EN
         csum = csum ^ x_pad[i*WORD_W +: WORD_W] ^ y_pad[i*WORD_W +: WORD_W];
`endif
      end
`ifdef ECC_SER_CHECKSUM_EN
      if (idx == IDX_W'(2*WPC))
         sel_word = csum;
`endif
   end

   assign data_out = data_ready ? sel_word : '0;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state      <= IDLE;
         idx        <= '0;
         cap_x      <= '0;
         cap_y      <= '0;
         data_ready <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (edone) begin
                  cap_x      <= Pox;
                  cap_y      <= Poy;
                  idx        <= '0;
                  data_ready <= 1'b1;
                  busy       <= 1'b1;
                  overrun    <= 1'b0;
                  state      <= SEND;
               end
            end
            SEND: begin
               // A new result while busy is flagged but never disturbs the held capture.
               if (edone)
                  overrun <= 1'b1;
               if (read_ack && data_ready) begin
                  idx <= idx + 1'b1;
                  if (idx == LAST_IDX) begin
                     data_ready <= 1'b0;
                     busy       <= 1'b0;
                     done       <= 1'b1;
                     state      <= DONE;
                  end
               end
            end
            DONE: begin
               if (edone)
                  overrun <= 1'b1;
               done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ecc_result_serializer.sv
// Scoreboard bench for ecc_result_serializer; honours ECC_SER_CHECKSUM_EN for the word count.
module tb_ecc_result_serializer;
   import ecc_io_pkg::*;

`ifdef ECC_SER_CHECKSUM_EN
   localparam int unsigned N_WORDS = 7;
`else
   localparam int unsigned N_WORDS = 6;
`endif
   localparam int NO_EVT = 1000;

   logic              clk = 1'b0;
   logic              n_rst;
   logic              edone;
   logic [ECC_W-1:0]  Pox;
   logic [ECC_W-1:0]  Poy;
   logic              read_ack;
   logic [WORD_W-1:0] data_out;
   logic              data_ready;
   logic              busy;
   logic              done;
   logic              overrun;

   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   word_t exp_q[$];
   word_t obs_q[$];
   int    done_cyc;
   int    last_cyc;
   int    post_idle;
   bit    stall_bad;

   always #5 clk = ~clk;

   ecc_result_serializer dut (
      .clk        (clk),
      .n_rst      (n_rst),
      .edone      (edone),
      .Pox        (Pox),
      .Poy        (Poy),
      .read_ack   (read_ack),
      .data_out   (data_out),
      .data_ready (data_ready),
      .busy       (busy),
      .done       (done),
      .overrun    (overrun)
   );

   // Reference word order: low word first, top word zero-padded, then checksum if enabled.
   task automatic push_words(input logic [ECC_W-1:0] x, input logic [ECC_W-1:0] y);
      word_t w[6];
      word_t cs;
      w[0] = x[63:0];
      w[1] = x[127:64];
      w[2] = {28'b0, x[163:128]};
      w[3] = y[63:0];
      w[4] = y[127:64];
      w[5] = {28'b0, y[163:128]};
      cs = '0;
      foreach (w[i]) begin
         exp_q.push_back(w[i]);
         cs ^= w[i];
      end
`ifdef ECC_SER_CHECKSUM_EN
      exp_q.push_back(cs);
`endif
   endtask

   // Called just after a negedge; returns at the negedge where the first word should be visible.
   task automatic fire(input logic [ECC_W-1:0] x, input logic [ECC_W-1:0] y);
      Pox   = x;
      Poy   = y;
      edone = 1'b1;
      push_words(x, y);
      @(negedge clk);
      edone = 1'b0;
      Pox   = ~x;
      Poy   = ~y;
   endtask

   // Monitor: records each acked word, stall stability, done timing and the cycle after done.
   task automatic collect(input int stall_at, input int stall_len, input int edone_at);
      word_t held;
      bit    stalled;
      obs_q.delete();
      done_cyc  = -1;
      last_cyc  = -1;
      post_idle = -1;
      stall_bad = 1'b0;
      held      = '0;
      for (int c = 0; c < 80; c++) begin
         if (done_cyc >= 0) begin
            post_idle = (busy || data_ready || done) ? 0 : 1;
            break;
         end
         if (done)
            done_cyc = c;
         stalled  = (c >= stall_at) && (c < stall_at + stall_len);
         read_ack = !stalled;
         if (stalled) begin
            if (c == stall_at)
               held = data_out;
            if (data_out !== held || data_ready !== 1'b1)
               stall_bad = 1'b1;
         end
         if (data_ready && read_ack) begin
            obs_q.push_back(data_out);
            last_cyc = c;
         end
         if (c == edone_at) begin
            edone = 1'b1;
            Pox   = 164'h1;
            Poy   = 164'h1;
         end else begin
            edone = 1'b0;
         end
         @(negedge clk);
      end
      read_ack = 1'b0;
      edone    = 1'b0;
   endtask

   task automatic test_reset();
      n_rst = 1'b0; edone = 1'b0; read_ack = 1'b0; Pox = '0; Poy = '0;
      repeat (2) @(negedge clk);
      vectors++;
      if ({data_out, data_ready, busy, done, overrun} !== 68'h0) begin
         miscompares++;
         $display("FAIL reset_state got %h want 0", {data_out, data_ready, busy, done, overrun});
      end
      n_rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      word_t e;
      read_ack = 1'b1;
      fire({4'hA, {160{1'b1}}}, 164'h0_1234_5678_9ABC_DEF0_0000_0000_FFFF_0000_1111_2222);
      vectors++;
      if (data_ready !== 1'b1 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL basic_latency got ready=%b busy=%b want 1 1", data_ready, busy);
      end
      collect(NO_EVT, 0, NO_EVT);
      vectors++;
      if (obs_q.size() != N_WORDS) begin
         miscompares++;
         $display("FAIL basic_count got %0d want %0d", obs_q.size(), N_WORDS);
      end
      vectors++;
      if (last_cyc != N_WORDS - 1) begin
         miscompares++;
         $display("FAIL basic_consecutive last word at cycle %0d want %0d", last_cyc, N_WORDS - 1);
      end
      if (obs_q.size() > 2) begin
         vectors++;
         if (obs_q[2] !== 64'h0000000AFFFFFFFF) begin
            miscompares++;
            $display("FAIL basic_w2 got %h want 0000000affffffff", obs_q[2]);
         end
      end
      foreach (obs_q[i]) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL basic_extra_word%0d got %h want none", i, obs_q[i]);
         end else begin
            e = exp_q.pop_front();
            if (obs_q[i] !== e) begin
               miscompares++;
               $display("FAIL basic_word%0d got %h want %h", i, obs_q[i], e);
            end
         end
      end
      vectors++;
      if (done_cyc < 0 || done_cyc != last_cyc + 1 || post_idle != 1) begin
         miscompares++;
         $display("FAIL basic_done got done_cyc=%0d post_idle=%0d want %0d 1", done_cyc, post_idle, last_cyc + 1);
      end
      exp_q.delete();
   endtask

   task automatic test_backpressure();
      word_t e;
      fire({41{4'h3}}, {41{4'h9}});
      collect(0, 5, NO_EVT);
      vectors++;
      if (stall_bad) begin
         miscompares++;
         $display("FAIL stall_hold got unstable data_out/data_ready want steady w0");
      end
      vectors++;
      if (obs_q.size() != N_WORDS || done_cyc != N_WORDS + 5) begin
         miscompares++;
         $display("FAIL stall_count got %0d words done_cyc=%0d want %0d %0d", obs_q.size(), done_cyc, N_WORDS, N_WORDS + 5);
      end
      foreach (obs_q[i]) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL stall_extra_word%0d got %h want none", i, obs_q[i]);
         end else begin
            e = exp_q.pop_front();
            if (obs_q[i] !== e) begin
               miscompares++;
               $display("FAIL stall_word%0d got %h want %h", i, obs_q[i], e);
            end
         end
      end
      exp_q.delete();
   endtask

   task automatic test_overrun();
      word_t e;
      fire({41{4'h5}}, {41{4'hC}});
      collect(NO_EVT, 0, 2);
      foreach (obs_q[i]) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL ovr_extra_word%0d got %h want none", i, obs_q[i]);
         end else begin
            e = exp_q.pop_front();
            if (obs_q[i] !== e) begin
               miscompares++;
               $display("FAIL ovr_word%0d got %h want %h", i, obs_q[i], e);
            end
         end
      end
      vectors++;
      if (overrun !== 1'b1 || obs_q.size() != N_WORDS) begin
         miscompares++;
         $display("FAIL ovr_flag got overrun=%b words=%0d want 1 %0d", overrun, obs_q.size(), N_WORDS);
      end
      exp_q.delete();
      fire({41{4'h6}}, {41{4'h7}});
      vectors++;
      if (overrun !== 1'b0) begin
         miscompares++;
         $display("FAIL ovr_clear got %b want 0", overrun);
      end
      collect(NO_EVT, 0, NO_EVT);
      foreach (obs_q[i]) begin
         vectors++;
         e = (exp_q.size() != 0) ? exp_q.pop_front() : ~obs_q[i];
         if (obs_q[i] !== e) begin
            miscompares++;
            $display("FAIL ovr_next_word%0d got %h want %h", i, obs_q[i], e);
         end
      end
      exp_q.delete();
   endtask

   task automatic test_async_reset();
      word_t e;
      bit    done_seen;
      read_ack = 1'b1;
      fire({41{4'hB}}, {41{4'h2}});
      for (int i = 0; i < 3; i++) begin
         e = exp_q.pop_front();
         vectors++;
         if (data_out !== e || data_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_pre_word%0d got %h want %h", i, data_out, e);
         end
         if (i < 2) @(negedge clk);
      end
      @(posedge clk);
      #2 n_rst = 1'b0;
      #1;
      vectors++;
      if ({data_ready, busy, data_out} !== 66'h0) begin
         miscompares++;
         $display("FAIL rst_async got ready=%b busy=%b data=%h want 0", data_ready, busy, data_out);
      end
      exp_q.delete();
      read_ack  = 1'b0;
      done_seen = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (done) done_seen = 1'b1;
      end
      n_rst = 1'b1;
      @(negedge clk);
      if (done) done_seen = 1'b1;
      vectors++;
      if (done_seen) begin
         miscompares++;
         $display("FAIL rst_no_done got done pulse want none");
      end
      fire({41{4'hD}}, {41{4'h4}});
      collect(NO_EVT, 0, NO_EVT);
      foreach (obs_q[i]) begin
         vectors++;
         e = (exp_q.size() != 0) ? exp_q.pop_front() : ~obs_q[i];
         if (obs_q[i] !== e) begin
            miscompares++;
            $display("FAIL rst_restart_word%0d got %h want %h", i, obs_q[i], e);
         end
      end
      vectors++;
      if (obs_q.size() != N_WORDS) begin
         miscompares++;
         $display("FAIL rst_restart_count got %0d want %0d", obs_q.size(), N_WORDS);
      end
      exp_q.delete();
   endtask

   task automatic test_final_ack_edone();
      fire({41{4'h8}}, {41{4'h1}});
      collect(NO_EVT, 0, N_WORDS - 1);
      vectors++;
      if (done_cyc != N_WORDS || overrun !== 1'b1 || post_idle != 1) begin
         miscompares++;
         $display("FAIL final_ack_edone got done_cyc=%0d overrun=%b post_idle=%0d want %0d 1 1", done_cyc, overrun, post_idle, N_WORDS);
      end
      exp_q.delete();
   endtask

   task automatic test_word_count();
      word_t e;
      fire({164{1'b1}}, {164{1'b1}});
      collect(NO_EVT, 0, NO_EVT);
      vectors++;
      if (obs_q.size() != N_WORDS) begin
         miscompares++;
         $display("FAIL count got %0d want %0d", obs_q.size(), N_WORDS);
      end
      foreach (obs_q[i]) begin
         vectors++;
         e = (exp_q.size() != 0) ? exp_q.pop_front() : ~obs_q[i];
         if (obs_q[i] !== e) begin
            miscompares++;
            $display("FAIL ones_word%0d got %h want %h", i, obs_q[i], e);
         end
      end
`ifdef ECC_SER_CHECKSUM_EN
      if (obs_q.size() > 6) begin
         vectors++;
         if (obs_q[6] !== 64'h0) begin
            miscompares++;
            $display("FAIL checksum got %h want 0", obs_q[6]);
         end
      end
`endif
      exp_q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_overrun();
      test_async_reset();
      test_final_ack_edone();
      test_word_count();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ecc_result_serializer.md
Name: ecc_result_serializer

Overview:
- Transmit-side counterpart to the controller's 64-bit word loader. Captures the 164-bit ECC result point (Pox, Poy) when the point-multiply engine signals edone, then streams it out as 64-bit words over a data_ready/read_ack handshake.
- Sits between the ECC engine and the host bus interface, and mirrors the word order the controller uses to assemble k/Pix/Piy.

Parameters:
- ECC_W, 164, coordinate width in bits
- WORD_W, 64, output word width in bits
- WPC, 3, words per coordinate, equal to ceil(ECC_W/WORD_W); the elaboration assertion fails if inconsistent

Ports:
- clk  in  1  system clock, rising edge
- n_rst  in  1  asynchronous, active-low reset
- edone  in  1  ECC engine done; sampled each cycle
- Pox  in  ECC_W  result x-coordinate, valid while edone=1
- Poy  in  ECC_W  result y-coordinate, valid while edone=1
- read_ack  in  1  host consumes the current word
- data_out  out  WORD_W  current output word
- data_ready  out  1  data_out is valid
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse after the last word is acked
- overrun  out  1  sticky flag: edone arrived while busy

Behaviour:
- Reset, asynchronous: all registers clear immediately. data_out=0, data_ready=0, busy=0, done=0, overrun=0, state=IDLE, idx=0.
- States: IDLE, SEND, DONE.
- IDLE:
  - edone=1 at edge N: capture Pox/Poy into internal 2*ECC_W register, idx<=0, go to SEND.
  - From edge N: data_ready=1, busy=1, data_out=word0. Latency from edone to first valid word is 1 cycle.
- SEND:
  - data_out always equals word[idx]; it is combinational from the captured register and idx, and stable while unacked.
  - read_ack && data_ready at an edge: idx<=idx+1.
  - read_ack on the last index: go to DONE.
  - read_ack=0: hold all state. There is no timeout.
- DONE: lasts one cycle.
  - data_ready=0, busy=0, done=1.
  - Next state IDLE; edone is not accepted in this cycle.
- Word order (WPC=3):
  - w0=Pox[63:0], w1=Pox[127:64], w2={28'b0,Pox[163:128]}
  - w3=Poy[63:0], w4=Poy[127:64], w5={28'b0,Poy[163:128]}
  - Total 6 words. Pad bits are always zero.
- data_out=0 whenever data_ready=0.
- idx width is clog2(2*WPC+1). idx never wraps, because the state changes on the final ack.
- overrun:
  - Set at any edge where edone=1 and state!=IDLE. The held capture is not disturbed.
  - Cleared at the next accepted capture in IDLE.
  - Simultaneous final read_ack and edone: the ack completes and overrun is set.
- read_ack while data_ready=0 is ignored.
- Reset mid-transfer abandons the transfer. No done pulse is produced.

Optional Feature:
- Macro: ECC_SER_CHECKSUM_EN.
- Defined:
  - A seventh word is appended after w5: the XOR of w0..w5.
  - Word count is 2*WPC+1.
  - done pulses after the checksum word is acked.
- Undefined: exactly 2*WPC words are sent, with no checksum logic or register.

Decomposition:
- Package ecc_io_pkg holds:
  - localparams ECC_W=164, WORD_W=64, WPC=3
  - typedef enum logic [1:0] {IDLE,SEND,DONE} ser_state_t
  - typedef logic [WORD_W-1:0] word_t
- The controller shares the same package constants.
- No sub-module. Word select is a single case mux inside the block.

Test Plan:
- Basic transfer:
  - Stimulus: reset 2 cycles, then edone=1 for 1 cycle with Pox={4'hA,{160{1'b1}}}, Poy=164'h0_1234_5678_9ABC_DEF0_0000_0000_FFFF_0000_1111_2222, read_ack held 1.
  - Response: w0..w5 appear on consecutive cycles, w2=64'h0000000AFFFFFFFF. done pulses exactly 1 cycle after w5 is acked, then busy=0.
- Backpressure:
  - Stimulus: read_ack=0 for 5 cycles after the first word, then 1.
  - Response: data_out holds w0 and data_ready stays 1 throughout the stall. All 6 words are still delivered in order, with no duplicates.
- Overrun:
  - Stimulus: during SEND, pulse edone with new Pox=164'h1.
  - Response: overrun=1 and the remaining words are from the original capture. On the next capture in IDLE, overrun clears to 0.
- Async reset mid-transfer:
  - Stimulus: drop n_rst off-edge after w2 is acked.
  - Response: data_ready, busy and data_out go to 0 immediately, and done never pulses. After release, a fresh edone restarts from w0.
- Simultaneous final ack and edone:
  - Response: done=1 next cycle, overrun=1, no new transfer started.
- With ECC_SER_CHECKSUM_EN:
  - Stimulus: Pox=Poy=all ones.
  - Response: 7 words; w6 = XOR of w0..w5 = 64'h0.
- Without ECC_SER_CHECKSUM_EN: 6 words.
